snn_add_acc: RTL and testbench

Parametrised, handshaked adder/accumulator for the SNN datapath. It is the successor to the fixed 4-bit adder. It adds:
- generic operand width;
- signed or unsigned arithmetic;
- saturate-or-wrap overflow handling;
- a running-accumulate mode, used for membrane-potential integration;
- valid/ready flow control on input and output.

It sits between spike-weight fetch and the neuron threshold compare. One result is issued per accepted input, and throughput is one per cycle.

---
 rtl/snn_add_acc.sv | 98 +++++++++
 tb/tb_snn_add_acc.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/snn_add_acc.sv
// Handshaked add / running-accumulate with saturate-or-wrap overflow for the SNN datapath.
// Latency: 1 cycle from accept to s/out_valid; one result per cycle when out_ready is held high.
// Backpressure: single output register; in_ready = !out_valid || out_ready, so stalls pass straight upstream.
module snn_add_acc #(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0,
    parameter bit SAT    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic             clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] U_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef struct packed {
        logic [WIDTH-1:0] val;
        logic             ovf;
    } res_t;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   addend_ext;
    logic [WIDTH:0]   sum;
    res_t             res;
    logic             accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        addend     = b;
        a_ext      = {1'b0, a};
        addend_ext = '0;
        res        = '0;
        // A clear on an accumulate starts the new integration from zero in the same cycle.
        if (mode) begin
            addend = clr ? '0 : acc;
        end
        if (SIGNED) begin
            a_ext      = {a[WIDTH-1], a};
            addend_ext = {addend[WIDTH-1], addend};
        end else begin
            addend_ext = {1'b0, addend};
        end
        sum     = a_ext + addend_ext;
        res.ovf = SIGNED ? (sum[WIDTH] ^ sum[WIDTH-1]) : sum[WIDTH];
        res.val = sum[WIDTH-1:0];
        // The extended top bit carries the true sign, so it picks the clamp direction.
        if (res.ovf && SAT) begin
            if (!SIGNED) begin
                res.val = U_MAX;
            end else if (sum[WIDTH]) begin
                res.val = S_MIN;
            end else begin
                res.val = S_MAX;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            s         <= '0;
            ovf       <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            s         <= res.val;
            ovf       <= res.ovf;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Clear is honoured even when no input is accepted, including during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (accept && mode) begin
            acc <= res.val;
        end else if (clr) begin
            acc <= '0;
        end
    end

endmodule

// File: tb/tb_snn_add_acc.sv
// Scoreboard bench: three builds (unsigned sat, unsigned wrap, signed sat) share one stimulus stream.
module tb_snn_add_acc;

    typedef struct packed {
        logic [3:0] s;
        logic       ovf;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       mode;
    logic       clr;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_ready;

    logic       ir_us, ir_uw, ir_ss;
    logic       ov_us, ov_uw, ov_ss;
    logic [3:0] s_us, s_uw, s_ss;
    logic       of_us, of_uw, of_ss;

    res_t q_us[$];
    res_t q_uw[$];
    res_t q_ss[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snn_add_acc #(.WIDTH(4), .SIGNED(1'b0), .SAT(1'b1)) u_us (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_us), .mode(mode), .clr(clr),
        .a(a), .b(b), .out_valid(ov_us), .out_ready(out_ready), .s(s_us), .ovf(of_us));

    snn_add_acc #(.WIDTH(4), .SIGNED(1'b0), .SAT(1'b0)) u_uw (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_uw), .mode(mode), .clr(clr),
        .a(a), .b(b), .out_valid(ov_uw), .out_ready(out_ready), .s(s_uw), .ovf(of_uw));

    snn_add_acc #(.WIDTH(4), .SIGNED(1'b1), .SAT(1'b1)) u_ss (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_ss), .mode(mode), .clr(clr),
        .a(a), .b(b), .out_valid(ov_ss), .out_ready(out_ready), .s(s_ss), .ovf(of_ss));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push3(input logic [3:0] us_s, input logic us_o,
                         input logic [3:0] uw_s, input logic uw_o,
                         input logic [3:0] ss_s, input logic ss_o);
        q_us.push_back('{us_s, us_o});
        q_uw.push_back('{uw_s, uw_o});
        q_ss.push_back('{ss_s, ss_o});
    endtask

    // Drive one transaction and hold it until accepted.
    task automatic send(input logic m, input logic c, input logic [3:0] va, input logic [3:0] vb,
                        input bit push,
                        input logic [3:0] us_s, input logic us_o,
                        input logic [3:0] uw_s, input logic uw_o,
                        input logic [3:0] ss_s, input logic ss_o);
        bit taken;
        taken    = 1'b0;
        mode     = m;
        clr      = c;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        if (push) push3(us_s, us_o, uw_s, uw_o, ss_s, ss_o);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ir_us) begin
                taken = 1'b1;
                break;
            end
        end
        if (!taken) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    // Monitor: every output transfer is popped and compared for all three builds.
    always @(negedge clk) begin
        res_t e;
        if (!rst && ov_us && out_ready) begin
            chk("ov_uw_match", {31'd0, ov_uw}, 32'd1);
            chk("ov_ss_match", {31'd0, ov_ss}, 32'd1);
            if (q_us.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                e = q_us.pop_front();
                chk("us_s", {28'd0, s_us}, {28'd0, e.s});
                chk("us_ovf", {31'd0, of_us}, {31'd0, e.ovf});
                e = q_uw.pop_front();
                chk("uw_s", {28'd0, s_uw}, {28'd0, e.s});
                chk("uw_ovf", {31'd0, of_uw}, {31'd0, e.ovf});
                e = q_ss.pop_front();
                chk("ss_s", {28'd0, s_ss}, {28'd0, e.s});
                chk("ss_ovf", {31'd0, of_ss}, {31'd0, e.ovf});
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        mode      = 1'b0;
        clr       = 1'b0;
        a         = 4'd0;
        b         = 4'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, ov_us}, 32'd0);
        chk("rst_s", {28'd0, s_us}, 32'd0);
        chk("rst_ovf", {31'd0, of_us}, 32'd0);
        chk("rst_in_ready", {31'd0, ir_us}, 32'd1);
        chk("rst_ss_s", {28'd0, s_ss}, 32'd0);
        @(posedge clk);
        #1;

        // Pairwise adds:                     us        uw        ss
        send(0, 0, 4'd3,  4'd4,  1, 4'd7,  0, 4'd7,  0, 4'd7,  0);
        send(0, 0, 4'd9,  4'd9,  1, 4'd15, 1, 4'd2,  1, 4'd8,  1);
        send(0, 0, 4'd8,  4'd15, 1, 4'd15, 1, 4'd7,  1, 4'd8,  1);
        send(0, 0, 4'd7,  4'd1,  1, 4'd8,  0, 4'd8,  0, 4'd7,  1);
        send(0, 0, 4'd13, 4'd2,  1, 4'd15, 0, 4'd15, 0, 4'd15, 0);

        // Accumulate chain starting with a clear, back to back.
        send(1, 1, 4'd5, 4'd0, 1, 4'd5,  0, 4'd5,  0, 4'd5, 0);
        send(1, 0, 4'd5, 4'd9, 1, 4'd10, 0, 4'd10, 0, 4'd7, 1);
        send(1, 0, 4'd5, 4'd9, 1, 4'd15, 0, 4'd15, 0, 4'd7, 1);
        send(1, 0, 4'd5, 4'd9, 1, 4'd15, 1, 4'd4,  1, 4'd7, 1);

        // Clear-only cycle, then a=1.
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        send(1, 0, 4'd1, 4'd0, 1, 4'd1, 0, 4'd1, 0, 4'd1, 0);
        // Mode 0 leaves acc alone; mode 0 with clr zeroes it.
        send(0, 0, 4'd2, 4'd3, 1, 4'd5, 0, 4'd5, 0, 4'd5, 0);
        send(1, 0, 4'd1, 4'd0, 1, 4'd2, 0, 4'd2, 0, 4'd2, 0);
        send(0, 1, 4'd1, 4'd1, 1, 4'd2, 0, 4'd2, 0, 4'd2, 0);
        send(1, 0, 4'd3, 4'd0, 1, 4'd3, 0, 4'd3, 0, 4'd3, 0);
        @(posedge clk);
        #1;

        // Backpressure: result 7 stalls, next input held pending for 3 cycles.
        out_ready = 1'b0;
        send(1, 0, 4'd4, 4'd0, 1, 4'd7, 0, 4'd7, 0, 4'd7, 0);
        mode     = 1'b1;
        a        = 4'd2;
        in_valid = 1'b1;
        push3(4'd9, 0, 4'd9, 0, 4'd7, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, ir_us}, 32'd0);
            chk("stall_out_valid", {31'd0, ov_us}, 32'd1);
            chk("stall_s", {28'd0, s_us}, 32'd7);
            chk("stall_ss_s", {28'd0, s_ss}, 32'd7);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", {31'd0, ir_us}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Reset while a result is pending and acc=10.
        out_ready = 1'b0;
        send(1, 1, 4'd10, 4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0);
        @(negedge clk);
        chk("pre_rst_s", {28'd0, s_us}, 32'd10);
        chk("pre_rst_out_valid", {31'd0, ov_us}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", {31'd0, ov_us}, 32'd0);
        chk("mid_rst_s", {28'd0, s_us}, 32'd0);
        chk("mid_rst_ovf", {31'd0, of_ss}, 32'd0);
        @(posedge clk);
        #1;
        send(1, 0, 4'd2, 4'd0, 1, 4'd2, 0, 4'd2, 0, 4'd2, 0);

        for (int i = 0; i < 20 && q_us.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain_queue", q_us.size(), 32'd0);
        chk("idle_out_valid", {31'd0, ov_us}, 32'd0);
        chk("idle_ready_match", {29'd0, ir_us, ir_uw, ir_ss}, 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
